mem_port_arbiter: RTL and testbench

Shares the single unified instruction/data memory of the multicycle CPU between two requesters: the CPU memory interface (fetch and lw/sw) and a DMA/program-loader port. Each requester uses a req/ack handshake. The arbiter serialises accesses, drives the memory command for a fixed MEM_LAT cycles, and returns read data with a one-cycle ack. It sits between the CPU controller/datapath and the memory block.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Serialises CPU and DMA/loader accesses onto the single memory port of the
// multicycle CPU. Each access holds the memory command for MEM_LAT cycles,
// then returns a one-cycle ack to its owner.
//
// state | meaning
// IDLE  | sample requests, pick owner, latch its command
// BUSY  | strobe held for MEM_LAT cycles, cnt counts down to zero
// ACK   | one-cycle ack to owner, requests ignored
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MEM_LAT      = 2,
  parameter int CPU_PRIORITY = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_dma
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic          sel_dma;
  logic          sel_we;

  // Owner for the current IDLE sample: a lone requester wins; on contention
  // either the CPU (fixed priority) or whoever did not own the last access.
  always_comb begin
    sel_dma = dma_req;
    if (cpu_req && dma_req) begin
      sel_dma = (CPU_PRIORITY != 0) ? 1'b0 : ~grant_dma;
    end
    sel_we = sel_dma ? dma_we : cpu_we;
  end

  // Arbiter FSM; every output is a register so the memory sees glitch-free strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
      grant_dma <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            grant_dma <= sel_dma;
            we_q      <= sel_we;
            mem_addr  <= sel_dma ? dma_addr : cpu_addr;
            mem_wdata <= sel_dma ? dma_wdata : cpu_wdata;
            mem_read  <= ~sel_we;
            mem_write <= sel_we;
            cnt       <= CNT_LOAD;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (!we_q) begin
              rdata <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            cpu_ack   <= ~grant_dma;
            dma_ack   <= grant_dma;
            state     <= ACK;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ACK: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          cpu_ack   <= 1'b0;
          dma_ack   <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Three instances: 0 = round-robin MEM_LAT=2,
// 1 = CPU priority MEM_LAT=2, 2 = round-robin MEM_LAT=1.
module tb_mem_port_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [N];
  logic        cpu_req   [N];
  logic        cpu_we    [N];
  logic [31:0] cpu_addr  [N];
  logic [31:0] cpu_wdata [N];
  logic        cpu_ack   [N];
  logic        dma_req   [N];
  logic        dma_we    [N];
  logic [31:0] dma_addr  [N];
  logic [31:0] dma_wdata [N];
  logic        dma_ack   [N];
  logic [31:0] rdata     [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic        mem_read  [N];
  logic        mem_write [N];
  logic [31:0] mem_rdata [N];
  logic        busy      [N];
  logic        grant_dma [N];
  logic        use_fn    [N];
  logic [31:0] rd_val    [N];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] memfunc(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 2) ? 1 : 2;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign mem_rdata[g] = use_fn[g] ? memfunc(mem_addr[g]) : rd_val[g];
    mem_port_arbiter #(
      .AW(32), .DW(32),
      .MEM_LAT((g == 2) ? 1 : 2),
      .CPU_PRIORITY((g == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .reset(rst[g]),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_ack(cpu_ack[g]),
      .dma_req(dma_req[g]), .dma_we(dma_we[g]), .dma_addr(dma_addr[g]),
      .dma_wdata(dma_wdata[g]), .dma_ack(dma_ack[g]),
      .rdata(rdata[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g]), .grant_dma(grant_dma[g])
    );
  end

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // Reference model: an access started at an IDLE sample occupies the port for
  // MEM_LAT strobe cycles plus one ack cycle; m_rem counts the cycles left.
  int          m_rem   [N];
  logic        m_own   [N];
  logic        m_we    [N];
  logic [31:0] m_addr  [N];
  logic [31:0] m_wdata [N];
  logic [31:0] m_rdata [N];
  logic        m_sel;

  always @(posedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (rst[d]) begin
        m_rem[d]   = 0;
        m_own[d]   = 1'b1;
        m_we[d]    = 1'b0;
        m_addr[d]  = '0;
        m_wdata[d] = '0;
        m_rdata[d] = '0;
      end else if (m_rem[d] == 0) begin
        if (cpu_req[d] || dma_req[d]) begin
          if (cpu_req[d] && dma_req[d]) m_sel = (d == 1) ? 1'b0 : ~m_own[d];
          else                          m_sel = dma_req[d];
          m_own[d]   = m_sel;
          m_we[d]    = m_sel ? dma_we[d] : cpu_we[d];
          m_addr[d]  = m_sel ? dma_addr[d] : cpu_addr[d];
          m_wdata[d] = m_sel ? dma_wdata[d] : cpu_wdata[d];
          m_rem[d]   = lat_of(d) + 1;
        end
      end else begin
        m_rem[d] = m_rem[d] - 1;
        if (m_rem[d] == 1 && !m_we[d]) m_rdata[d] = memfunc(m_addr[d]);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      rst[d] = 1'b1; cpu_req[d] = 1'b0; dma_req[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < N; d++) rst[d] = 1'b0;
  endtask

  // One isolated transaction on instance d, watched cycle by cycle.
  task automatic run_txn(input int d, input bit is_dma, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] memval, input logic [31:0] exp_rd,
                         input string tag);
    int  lat     = lat_of(d);
    int  strobes = 0;
    int  own_n   = 0;
    int  oth_n   = 0;
    int  ack_k   = -1;
    int  bad_cmd = 0;
    int  wrong   = 0;
    logic own_ack;
    logic oth_ack;
    use_fn[d] = 1'b0;
    rd_val[d] = memval;
    @(negedge clk);
    if (is_dma) begin
      dma_req[d] = 1'b1; dma_we[d] = we; dma_addr[d] = addr; dma_wdata[d] = wdata;
    end else begin
      cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wdata;
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      own_ack = is_dma ? dma_ack[d] : cpu_ack[d];
      oth_ack = is_dma ? cpu_ack[d] : dma_ack[d];
      if (we ? mem_write[d] : mem_read[d]) begin
        strobes++;
        if (mem_addr[d] !== addr || (we && mem_wdata[d] !== wdata)) bad_cmd++;
      end
      if (we ? mem_read[d] : mem_write[d]) wrong++;
      if (oth_ack) oth_n++;
      if (own_ack) begin
        own_n++;
        if (ack_k < 0) ack_k = k;
        if (is_dma) dma_req[d] = 1'b0; else cpu_req[d] = 1'b0;
      end
      if (k > lat + 1 && !busy[d]) break;
    end
    cpu_req[d] = 1'b0; dma_req[d] = 1'b0;
    chk_i({tag, " strobe_cycles"}, strobes, lat);
    chk_i({tag, " cmd_errors"}, bad_cmd, 0);
    chk_i({tag, " wrong_strobe"}, wrong, 0);
    chk_i({tag, " ack_cycle"}, ack_k, lat + 1);
    chk_i({tag, " ack_count"}, own_n, 1);
    chk_i({tag, " other_ack"}, oth_n, 0);
    chk_v({tag, " rdata"}, rdata[d], exp_rd);
    chk_i({tag, " grant_dma"}, int'(grant_dma[d]), int'(is_dma));
  endtask

  // Both requesters held; CPU drops after cpu_stop acks. Records grant order.
  task automatic both_run(input int d, input int n, input int cpu_stop,
                          output string order, output int errs);
    int   lat    = lat_of(d);
    int   acks   = 0;
    int   c_done = 0;
    int   last_k = -1;
    logic prev   = 1'b0;
    order = "";
    errs  = 0;
    use_fn[d] = 1'b1;
    @(negedge clk);
    cpu_req[d] = 1'b1; cpu_we[d] = 1'b0; cpu_addr[d] = $urandom;
    dma_req[d] = 1'b1; dma_we[d] = 1'b0; dma_addr[d] = $urandom;
    for (int k = 1; k <= n * 8 + 8; k++) begin
      @(negedge clk);
      if (mem_read[d] && mem_write[d]) errs++;
      if (cpu_ack[d] && dma_ack[d]) errs++;
      if (prev && (cpu_ack[d] || dma_ack[d])) errs++;
      prev = cpu_ack[d] | dma_ack[d];
      if (cpu_ack[d] || dma_ack[d]) begin
        if (last_k >= 0 && k - last_k != lat + 2) errs++;
        last_k = k;
      end
      if (cpu_ack[d]) begin
        order = {order, "C"}; acks++; c_done++;
        if (c_done >= cpu_stop) cpu_req[d] = 1'b0; else cpu_addr[d] = $urandom;
      end
      if (dma_ack[d]) begin
        order = {order, "D"}; acks++; dma_addr[d] = $urandom;
      end
      if (acks >= n) break;
    end
    cpu_req[d] = 1'b0; dma_req[d] = 1'b0;
    repeat (lat + 3) @(negedge clk);
  endtask

  typedef struct {
    bit          is_dma;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memval;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input bit is_dma, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] memval,
                              input logic [31:0] exp_rd);
    vec_t v;
    v.is_dma = is_dma; v.we = we; v.addr = addr; v.wdata = wdata;
    v.memval = memval; v.exp_rd = exp_rd;
    return v;
  endfunction

  vec_t  vecs [6];
  string ord;
  int    errs;
  int    ack_k [3];
  int    acks;
  int    addr_err;
  logic [31:0] cur;
  int    c_idle [N];
  int    d_idle [N];
  int    done_n [N];
  logic [5:0] e_v;
  logic [5:0] a_v;
  logic  e_strobe;

  initial begin
    vecs[0] = mk(0, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vecs[1] = mk(1, 1, 32'h0000_0040, 32'h1234_5678, 32'hCAFE_F00D, 32'hDEAD_BEEF);
    vecs[2] = mk(0, 0, 32'h0000_0040, 32'h0,         32'h1234_5678, 32'h1234_5678);
    vecs[3] = mk(1, 0, 32'h0000_0080, 32'h0,         32'h0BAD_F00D, 32'h0BAD_F00D);
    vecs[4] = mk(0, 1, 32'h0000_0044, 32'hA5A5_A5A5, 32'h0,         32'h0BAD_F00D);
    vecs[5] = mk(0, 0, 32'hFFFF_FFFC, 32'h0,         32'h0,         32'h0);

    for (int d = 0; d < N; d++) begin
      rst[d] = 1'b1; cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
      dma_req[d] = 1'b0; dma_we[d] = 1'b0; dma_addr[d] = '0; dma_wdata[d] = '0;
      use_fn[d] = 1'b0; rd_val[d] = '0;
      c_idle[d] = 0; d_idle[d] = 0; done_n[d] = 0;
    end
    repeat (2) @(negedge clk);

    for (int d = 0; d < N; d++) begin
      chk_i($sformatf("reset ctl%0d", d),
            int'({cpu_ack[d], dma_ack[d], mem_read[d], mem_write[d], busy[d], grant_dma[d]}),
            int'(6'b000001));
      chk_v($sformatf("reset rdata%0d", d), rdata[d], 32'h0);
      chk_v($sformatf("reset mem_addr%0d", d), mem_addr[d], 32'h0);
      chk_v($sformatf("reset mem_wdata%0d", d), mem_wdata[d], 32'h0);
      rst[d] = 1'b0;
    end

    for (int i = 0; i < 6; i++) begin
      run_txn(0, vecs[i].is_dma, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].memval, vecs[i].exp_rd, $sformatf("vec%0d", i));
    end

    do_reset();
    both_run(0, 4, 1000, ord, errs);
    chk_s("rr order", ord, "CDCD");
    chk_i("rr protocol", errs, 0);

    do_reset();
    both_run(1, 5, 4, ord, errs);
    chk_s("prio order", ord, "CCCCD");
    chk_i("prio protocol", errs, 0);

    // MEM_LAT=1, back-to-back CPU reads, next address presented during ACK
    do_reset();
    use_fn[2] = 1'b1;
    acks = 0; addr_err = 0; cur = 32'h0000_0100;
    for (int i = 0; i < 3; i++) ack_k[i] = -1;
    @(negedge clk);
    cpu_req[2] = 1'b1; cpu_we[2] = 1'b0; cpu_addr[2] = cur;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_read[2] && mem_addr[2] !== cur) addr_err++;
      if (cpu_ack[2]) begin
        ack_k[acks] = k;
        chk_v($sformatf("lat1 rdata%0d", acks), rdata[2], memfunc(cur));
        acks++;
        cur = cur + 32'd4;
        cpu_addr[2] = cur;
        if (acks == 3) break;
      end
    end
    cpu_req[2] = 1'b0;
    chk_i("lat1 ack0 cycle", ack_k[0], 2);
    chk_i("lat1 ack1 cycle", ack_k[1], 5);
    chk_i("lat1 ack2 cycle", ack_k[2], 8);
    chk_i("lat1 addr errors", addr_err, 0);
    repeat (3) @(negedge clk);

    // reset in the second BUSY cycle of a DMA read
    use_fn[0] = 1'b0; rd_val[0] = 32'h7777_7777;
    @(negedge clk);
    dma_req[0] = 1'b1; dma_we[0] = 1'b0; dma_addr[0] = 32'h0000_0200;
    @(negedge clk);
    chk_i("abort busy1 read", int'(mem_read[0]), 1);
    @(negedge clk);
    chk_i("abort busy2 read", int'(mem_read[0]), 1);
    #1 rst[0] = 1'b1;
    #1;
    chk_i("abort ctl", int'({cpu_ack[0], dma_ack[0], mem_read[0], mem_write[0], busy[0]}), 0);
    dma_req[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk_i("abort acks in reset", int'({cpu_ack[0], dma_ack[0]}), 0);
    rst[0] = 1'b0;
    both_run(0, 2, 1000, ord, errs);
    chk_s("post-abort order", ord, "CD");
    chk_i("post-abort protocol", errs, 0);

    // randomized traffic on all instances against the reference model
    for (int d = 0; d < N; d++) use_fn[d] = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        e_strobe = (m_rem[d] >= 2);
        e_v = {m_rem[d] == 1 && !m_own[d], m_rem[d] == 1 && m_own[d],
               e_strobe && !m_we[d], e_strobe && m_we[d], m_rem[d] > 0, m_own[d]};
        a_v = {cpu_ack[d], dma_ack[d], mem_read[d], mem_write[d], busy[d], grant_dma[d]};
        chk_i($sformatf("rand%0d ctl @%0d", d, cyc), int'(a_v), int'(e_v));
        chk_v($sformatf("rand%0d rdata @%0d", d, cyc), rdata[d], m_rdata[d]);
        if (e_strobe) chk_v($sformatf("rand%0d mem_addr @%0d", d, cyc), mem_addr[d], m_addr[d]);
        if (e_strobe && m_we[d]) chk_v($sformatf("rand%0d mem_wdata @%0d", d, cyc), mem_wdata[d], m_wdata[d]);
      end
      for (int d = 0; d < N; d++) begin
        if (cpu_req[d] && cpu_ack[d]) begin
          done_n[d]++;
          if ($urandom_range(1, 0) == 1) begin
            cpu_we[d] = $urandom_range(1, 0) == 1; cpu_addr[d] = $urandom; cpu_wdata[d] = $urandom;
          end else begin
            cpu_req[d] = 1'b0; c_idle[d] = $urandom_range(3, 0);
          end
        end else if (!cpu_req[d]) begin
          if (c_idle[d] > 0) c_idle[d]--;
          else if ($urandom_range(3, 0) != 0) begin
            cpu_req[d] = 1'b1;
            cpu_we[d] = $urandom_range(1, 0) == 1; cpu_addr[d] = $urandom; cpu_wdata[d] = $urandom;
          end
        end
        if (dma_req[d] && dma_ack[d]) begin
          done_n[d]++;
          if ($urandom_range(1, 0) == 1) begin
            dma_we[d] = $urandom_range(1, 0) == 1; dma_addr[d] = $urandom; dma_wdata[d] = $urandom;
          end else begin
            dma_req[d] = 1'b0; d_idle[d] = $urandom_range(3, 0);
          end
        end else if (!dma_req[d]) begin
          if (d_idle[d] > 0) d_idle[d]--;
          else if ($urandom_range(3, 0) != 0) begin
            dma_req[d] = 1'b1;
            dma_we[d] = $urandom_range(1, 0) == 1; dma_addr[d] = $urandom; dma_wdata[d] = $urandom;
          end
        end
      end
    end
    for (int d = 0; d < N; d++) begin
      chk_i($sformatf("rand%0d progress", d), int'(done_n[d] >= 50), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
